// File: rtl/pc_fetch_sequencer.sv
// Multi-cycle fetch/execute controller: owns the PC and instruction register,
// fetches one instruction, runs it on the datapath, then retires it.
module pc_fetch_sequencer #(
   parameter int                   PC_WIDTH    = 8,
   parameter int                   INSTR_WIDTH = 8,
   parameter logic [PC_WIDTH-1:0]  RESET_PC    = '0,
   parameter logic [4:0]           HALT_OPCODE = 5'b01111,
   parameter int                   CNT_WIDTH   = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   run_en,
   output logic                   imem_req,
   output logic [PC_WIDTH-1:0]    imem_addr,
   input  logic                   imem_ack,
   input  logic [INSTR_WIDTH-1:0] imem_rdata,
   output logic [INSTR_WIDTH-1:0] instr,
   output logic [4:0]             opcode,
   output logic                   exec_start,
   input  logic                   ex_done,
   input  logic                   pc_sel,
   input  logic [PC_WIDTH-1:0]    branch_target,
   output logic [PC_WIDTH-1:0]    pc,
   output logic                   halted,
   output logic [CNT_WIDTH-1:0]   retire_cnt
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_FETCH = 2'd1;
   localparam logic [1:0] ST_EXEC  = 2'd2;
   localparam logic [1:0] ST_HALT  = 2'd3;

   localparam logic [PC_WIDTH-1:0]  PC_ONE  = {{(PC_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

   logic [1:0]             state_q, state_d;
   logic [PC_WIDTH-1:0]    pc_q, pc_d;
   logic [INSTR_WIDTH-1:0] instr_q, instr_d;
   logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
   logic                   first_q, first_d;

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      cnt_d   = cnt_q;
      first_d = first_q;
      case (state_q)
         ST_IDLE: begin
            if (run_en) state_d = ST_FETCH;
         end
         ST_FETCH: begin
            // run_en is not looked at here: an issued request always completes.
            if (imem_ack) begin
               instr_d = imem_rdata;
               first_d = 1'b1;
               state_d = ST_EXEC;
            end
         end
         ST_EXEC: begin
            first_d = 1'b0;
            if (ex_done) begin
               cnt_d = cnt_q + CNT_ONE;
               if (opcode == HALT_OPCODE) begin
                  state_d = ST_HALT;
               end else begin
                  pc_d    = pc_sel ? branch_target : pc_q + PC_ONE;
                  state_d = run_en ? ST_FETCH : ST_IDLE;
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         pc_q    <= RESET_PC;
         instr_q <= '0;
         cnt_q   <= '0;
         first_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
         cnt_q   <= cnt_d;
         first_q <= first_d;
      end
   end

   // Strobes decode straight from state so reset clears them without a clock.
   assign imem_req   = (state_q == ST_FETCH);
   assign imem_addr  = pc_q;
   assign exec_start = (state_q == ST_EXEC) && first_q;
   assign halted     = (state_q == ST_HALT);
   assign instr      = instr_q;
   assign opcode     = instr_q[INSTR_WIDTH-1 -: 5];
   assign pc         = pc_q;
   assign retire_cnt = cnt_q;

endmodule

// File: doc/pc_fetch_sequencer.md
Name: pc_fetch_sequencer

Overview:
Multi-cycle fetch/execute controller for the 8-bit core.
- Owns the program counter and the instruction register.
- Issues requests to instruction memory and starts the datapath for each instruction.
- Uses the branch decision result (pc_sel) to choose between the sequential PC and the branch target when the instruction retires.
- Sits between instruction memory, the decode/ALU datapath, and the branch decision logic.

Parameters:
- PC_WIDTH, 8, program counter and instruction address width.
- INSTR_WIDTH, 8, instruction word width; the opcode is the top 5 bits.
- RESET_PC, 0, PC value loaded on reset.
- HALT_OPCODE, 5'b01111, opcode that stops sequencing.
- CNT_WIDTH, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- run_en  in  1  1 = sequencer may start new fetches.
- imem_req  out  1  instruction fetch request.
- imem_addr  out  PC_WIDTH  fetch address; always equals pc.
- imem_ack  in  1  fetch complete; imem_rdata valid this cycle.
- imem_rdata  in  INSTR_WIDTH  fetched instruction word.
- instr  out  INSTR_WIDTH  instruction register.
- opcode  out  5  instr[INSTR_WIDTH-1 -: 5], combinational from instr; feeds the branch decision logic.
- exec_start  out  1  one-cycle pulse; datapath begins executing instr.
- ex_done  in  1  datapath finished; ALU flags and branch_target are valid.
- pc_sel  in  1  1 = take branch_target at retire.
- branch_target  in  PC_WIDTH  branch/jump destination.
- pc  out  PC_WIDTH  current program counter.
- halted  out  1  sequencer is in HALT.
- retire_cnt  out  CNT_WIDTH  count of retired instructions.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE, pc=RESET_PC, instr=0, retire_cnt=0.
  - imem_req=0, exec_start=0, halted=0.
  - Outputs take these values immediately, including when reset asserts mid-fetch or mid-execute.
- States: IDLE, FETCH, EXEC, HALT.
- IDLE:
  - All strobes 0.
  - run_en=1 → FETCH on the next edge.
- FETCH:
  - imem_req=1 and imem_addr=pc, held stable until imem_ack.
  - On the imem_ack cycle: instr←imem_rdata, then EXEC.
  - An ack in the first FETCH cycle is legal, giving 1-cycle fetch latency.
  - Once a request is issued it is always completed, even if run_en drops.
- EXEC:
  - exec_start=1 in the first EXEC cycle only.
  - ex_done is sampled in every EXEC cycle, including the first (single-cycle ops).
  - On ex_done, the instruction retires:
    - retire_cnt+1, wrapping modulo 2^CNT_WIDTH.
    - If opcode==HALT_OPCODE: pc unchanged (points at the halt instruction), go to HALT; pc_sel is ignored.
    - Otherwise pc←pc_sel ? branch_target : pc+1, where pc+1 wraps modulo 2^PC_WIDTH (0xFF→0x00 at default width).
    - Next state: FETCH if run_en=1, else IDLE.
- HALT:
  - halted=1, all strobes 0.
  - Exits only via reset; run_en is ignored.
- Ignored inputs:
  - imem_ack outside FETCH.
  - ex_done outside EXEC.
  - pc_sel and branch_target on any cycle other than a retire.
- Throughput: minimum 2 cycles per instruction (FETCH with immediate ack, then EXEC with ex_done in the first cycle).
- Back-to-back retires always re-enter FETCH; there is no prefetch or overlap.
- instr holds its value until the next successful fetch.

Test Plan:
- Reset/idle: hold rst_n=0, then release with run_en=0 → pc=0x00, imem_req=0, halted=0, retire_cnt=0 for 10 cycles.
- Sequential run with zero-wait memory and single-cycle execute: run_en=1, imem_ack immediate, ex_done immediate, pc_sel=0 → imem_addr 0x00, 0x01, 0x02 on every second cycle; exec_start pulses once per instruction; retire_cnt=3 after 6 cycles.
- Taken branch: at pc=0x05, ex_done=1, pc_sel=1, branch_target=0x40 → next imem_addr=0x40 and retire_cnt increments. Repeat with pc_sel=0 → next address 0x06.
- Wait states and wrap-around:
  - imem_ack delayed 3 cycles → imem_req and imem_addr held stable for all 4 cycles.
  - ex_done delayed 2 cycles → exec_start high only in the first EXEC cycle.
  - pc=0xFF, not taken → next pc=0x00.
- run_en drop mid-fetch: deassert run_en while imem_req=1 → fetch completes on ack, the instruction executes and retires, then IDLE with imem_req=0.
- Halt and reset mid-operation:
  - instr with opcode 5'b01111 retires → halted=1, pc unchanged, no further imem_req despite run_en=1.
  - Pulse rst_n=0 during a FETCH → imem_req falls asynchronously and pc returns to 0x00.
